// File: rtl/line_period_capture.sv
// rtl/line_period_capture.sv - latches first valid period per pixel of a line and streams them out in pixel order
module line_period_capture #(
   parameter int NUM_PIXELS     = 8,
   parameter int COUNTER_BITS   = 15,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int IDX_BITS       = $clog2(NUM_PIXELS)
) (
   input  logic                               CLK,
   input  logic                               RST,
   input  logic                               START,
   input  logic [NUM_PIXELS*COUNTER_BITS-1:0] PERIOD_IN,
   input  logic [NUM_PIXELS-1:0]              PULSE_IN,
   output logic [COUNTER_BITS-1:0]            DATA_OUT,
   output logic [IDX_BITS-1:0]                INDEX_OUT,
   output logic                               VALID_OUT,
   input  logic                               READY_IN,
   output logic                               LAST_OUT,
   output logic                               BUSY,
   output logic                               TIMEOUT_FLAG,
   output logic                               DONE
);

   localparam int                    CNT_BITS = $clog2(TIMEOUT_CYCLES);
   localparam logic [IDX_BITS-1:0]   LAST_IDX = IDX_BITS'(NUM_PIXELS - 1);
   localparam logic [CNT_BITS-1:0]   CNT_MAX  = CNT_BITS'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_STREAM
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [NUM_PIXELS-1:0]   mask;
   logic [NUM_PIXELS-1:0]   mask_next;
   logic [COUNTER_BITS-1:0] cap [NUM_PIXELS];
   logic [CNT_BITS-1:0]     tcnt;
   logic [IDX_BITS-1:0]     idx;
   logic                    timeout_q;
   logic                    done_q;
   logic                    arm;
   logic                    beat;
   logic                    last_beat;
   logic                    complete;
   logic                    expire;

   // Completion looks at the mask including this edge's captures, so it beats a coincident timeout.
   always_comb begin
      state_next = state;
      arm        = 1'b0;
      beat       = 1'b0;
      last_beat  = 1'b0;
      expire     = 1'b0;
      mask_next  = mask | PULSE_IN;
      complete   = &mask_next;
      case (state)
         ST_IDLE: begin
            if (START) begin
               arm        = 1'b1;
               state_next = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if (complete) begin
               state_next = ST_STREAM;
            end else if (tcnt == CNT_MAX) begin
               expire     = 1'b1;
               state_next = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (READY_IN) begin
               beat = 1'b1;
               if (idx == LAST_IDX) begin
                  last_beat  = 1'b1;
                  state_next = ST_IDLE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         mask      <= '0;
         tcnt      <= '0;
         idx       <= '0;
         timeout_q <= 1'b0;
         done_q    <= 1'b0;
         for (int i = 0; i < NUM_PIXELS; i++) begin
            cap[i] <= '1;
         end
      end else begin
         done_q <= last_beat;
         // All-ones preset marks pixels that never report a measurement.
         if (arm) begin
            mask      <= '0;
            tcnt      <= '0;
            timeout_q <= 1'b0;
            for (int i = 0; i < NUM_PIXELS; i++) begin
               cap[i] <= '1;
            end
         end
         if (state == ST_COLLECT) begin
            mask <= mask_next;
            for (int i = 0; i < NUM_PIXELS; i++) begin
               if (PULSE_IN[i] && !mask[i]) begin
                  cap[i] <= PERIOD_IN[i*COUNTER_BITS +: COUNTER_BITS];
               end
            end
            if (tcnt != CNT_MAX) begin
               tcnt <= tcnt + CNT_BITS'(1);
            end
            if (expire) begin
               timeout_q <= 1'b1;
            end
         end
         if (beat) begin
            idx <= last_beat ? '0 : idx + IDX_BITS'(1);
         end
      end
   end

   assign VALID_OUT    = (state == ST_STREAM);
   assign BUSY         = (state != ST_IDLE);
   assign DATA_OUT     = VALID_OUT ? cap[idx] : '0;
   assign INDEX_OUT    = idx;
   assign LAST_OUT     = VALID_OUT && (idx == LAST_IDX);
   assign TIMEOUT_FLAG = timeout_q;
   assign DONE         = done_q;

endmodule

// File: tb/tb_line_period_capture.sv
// tb/tb_line_period_capture.sv - directed and randomized checks of line_period_capture against a first-pulse-wins model
module tb_line_period_capture;

   localparam int NP = 4;
   localparam int CB = 15;
   localparam int TO = 64;
   localparam int IB = 2;

   typedef logic [NP*CB-1:0] per_t;

   logic          CLK = 1'b0;
   logic          RST;
   logic          START;
   per_t          PERIOD_IN;
   logic [NP-1:0] PULSE_IN;
   logic [CB-1:0] DATA_OUT;
   logic [IB-1:0] INDEX_OUT;
   logic          VALID_OUT;
   logic          READY_IN;
   logic          LAST_OUT;
   logic          BUSY;
   logic          TIMEOUT_FLAG;
   logic          DONE;

   line_period_capture #(
      .NUM_PIXELS    (NP),
      .COUNTER_BITS  (CB),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .START       (START),
      .PERIOD_IN   (PERIOD_IN),
      .PULSE_IN    (PULSE_IN),
      .DATA_OUT    (DATA_OUT),
      .INDEX_OUT   (INDEX_OUT),
      .VALID_OUT   (VALID_OUT),
      .READY_IN    (READY_IN),
      .LAST_OUT    (LAST_OUT),
      .BUSY        (BUSY),
      .TIMEOUT_FLAG(TIMEOUT_FLAG),
      .DONE        (DONE)
   );

   always #5 CLK = ~CLK;

   int vectors     = 0;
   int miscompares = 0;

   logic [NP-1:0] stim_pulse [TO];
   per_t          stim_per   [TO];
   bit            stim_start [TO];
   bit            rdy_pat    [32];
   int            rdy_len;
   bit            start_in_stream;

   // Reference: each pixel keeps the period of its first pulse after START, else all-ones.
   logic [CB-1:0] m_cap [NP];
   logic [NP-1:0] m_mask;
   bit            m_to;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_stim();
      for (int j = 0; j < TO; j++) begin
         stim_pulse[j] = '0;
         stim_per[j]   = per_t'({$urandom(), $urandom()});
         stim_start[j] = 1'b0;
      end
      rdy_len         = 0;
      start_in_stream = 1'b0;
   endtask

   task automatic set_pulse(input int cyc, input int px, input logic [CB-1:0] val);
      stim_pulse[cyc][px]          = 1'b1;
      stim_per[cyc][px*CB +: CB]   = val;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, 32'(VALID_OUT), 32'd0);
      check({tag, "_last"},  32'(LAST_OUT),  32'd0);
      check({tag, "_busy"},  32'(BUSY),      32'd0);
      check({tag, "_done"},  32'(DONE),      32'd0);
      check({tag, "_tflag"}, 32'(TIMEOUT_FLAG), 32'd0);
      check({tag, "_index"}, 32'(INDEX_OUT), 32'd0);
      check({tag, "_data"},  32'(DATA_OUT),  32'd0);
   endtask

   task automatic run_collect(input bit coincident);
      START     = 1'b1;
      PULSE_IN  = coincident ? '1 : '0;
      PERIOD_IN = per_t'({$urandom(), $urandom()});
      @(negedge CLK);
      START    = 1'b0;
      check("busy_at_start",  32'(BUSY), 32'd1);
      check("valid_at_start", 32'(VALID_OUT), 32'd0);
      check("tflag_cleared",  32'(TIMEOUT_FLAG), 32'd0);
      for (int i = 0; i < NP; i++) m_cap[i] = '1;
      m_mask = '0;
      m_to   = 1'b0;
      for (int j = 0; j < TO; j++) begin
         PULSE_IN  = stim_pulse[j];
         PERIOD_IN = stim_per[j];
         START     = stim_start[j];
         for (int i = 0; i < NP; i++) begin
            if (stim_pulse[j][i] && !m_mask[i]) begin
               m_cap[i]  = stim_per[j][i*CB +: CB];
               m_mask[i] = 1'b1;
            end
         end
         @(negedge CLK);
         if (&m_mask) break;
         if (j == TO - 1) begin
            m_to = 1'b1;
            break;
         end
         check("collect_busy",     32'(BUSY), 32'd1);
         check("collect_no_valid", 32'(VALID_OUT), 32'd0);
      end
      START    = 1'b0;
      PULSE_IN = '0;
   endtask

   task automatic run_stream(input int abort_at);
      int exp_idx  = 0;
      int beats    = 0;
      bit finished = 1'b0;
      for (int c = 0; c < 64; c++) begin
         check("s_valid", 32'(VALID_OUT), 32'd1);
         check("s_index", 32'(INDEX_OUT), 32'(exp_idx));
         check("s_data",  32'(DATA_OUT),  32'(m_cap[exp_idx]));
         check("s_last",  32'(LAST_OUT),  32'(exp_idx == NP - 1));
         check("s_tflag", 32'(TIMEOUT_FLAG), 32'(m_to));
         check("s_done",  32'(DONE), 32'd0);
         check("s_busy",  32'(BUSY), 32'd1);
         if (exp_idx == abort_at) begin
            #2 RST = 1'b1;
            #1 check_reset_outputs("abort");
            @(negedge CLK);
            check("abort_no_done", 32'(DONE), 32'd0);
            RST      = 1'b0;
            READY_IN = 1'b0;
            PULSE_IN = '0;
            return;
         end
         READY_IN  = (c < rdy_len) ? rdy_pat[c] : 1'b1;
         PULSE_IN  = NP'($urandom());
         PERIOD_IN = per_t'({$urandom(), $urandom()});
         START     = start_in_stream && (c == 1);
         @(negedge CLK);
         START = 1'b0;
         if (READY_IN) begin
            beats++;
            if (exp_idx == NP - 1) begin
               check("done_pulse",   32'(DONE), 32'd1);
               check("done_busy",    32'(BUSY), 32'd0);
               check("done_valid",   32'(VALID_OUT), 32'd0);
               check("done_tflag",   32'(TIMEOUT_FLAG), 32'(m_to));
               check("beat_count",   32'(beats), 32'(NP));
               finished = 1'b1;
               break;
            end
            exp_idx++;
         end
      end
      check("stream_finished", 32'(finished), 32'd1);
      READY_IN = 1'b0;
      PULSE_IN = '0;
      @(negedge CLK);
      check("idle_done_low", 32'(DONE), 32'd0);
      check("idle_busy",     32'(BUSY), 32'd0);
      check("tflag_held",    32'(TIMEOUT_FLAG), 32'(m_to));
   endtask

   initial begin
      RST       = 1'b1;
      START     = 1'b0;
      READY_IN  = 1'b0;
      PULSE_IN  = '0;
      PERIOD_IN = '0;
      repeat (3) @(negedge CLK);
      check_reset_outputs("reset");
      RST = 1'b0;
      @(negedge CLK);

      // Staggered pulses on pixels 2, 0, 3, 1
      clear_stim();
      set_pulse(0, 2, 15'h0019);
      set_pulse(2, 0, 15'h00FA);
      set_pulse(4, 3, 15'h0005);
      set_pulse(6, 1, 15'h0C35);
      run_collect(1'b0);
      run_stream(-1);

      // All pixels on one edge; later pixel-1 pulses must not overwrite
      clear_stim();
      stim_pulse[0] = '1;
      set_pulse(1, 1, 15'h1234);
      set_pulse(2, 1, 15'h4321);
      run_collect(1'b0);
      run_stream(-1);

      // Pixel 3 never pulses: timeout, sentinel, flag held until next START
      clear_stim();
      for (int j = 0; j < TO; j++) stim_pulse[j] = NP'($urandom()) & 4'b0111;
      run_collect(1'b0);
      run_stream(-1);

      // Back-pressure pattern
      clear_stim();
      stim_pulse[0] = 4'b0101;
      stim_pulse[1] = 4'b1010;
      rdy_len = 7;
      rdy_pat[0] = 1; rdy_pat[1] = 0; rdy_pat[2] = 0; rdy_pat[3] = 1;
      rdy_pat[4] = 1; rdy_pat[5] = 0; rdy_pat[6] = 1;
      run_collect(1'b0);
      run_stream(-1);

      // Async reset mid-stream at index 2, then a fresh line
      clear_stim();
      stim_pulse[0] = '1;
      run_collect(1'b0);
      run_stream(2);
      clear_stim();
      set_pulse(1, 0, 15'h0111);
      set_pulse(1, 1, 15'h0222);
      set_pulse(3, 2, 15'h0333);
      set_pulse(5, 3, 15'h0444);
      run_collect(1'b0);
      run_stream(-1);

      // Extra STARTs in COLLECT and STREAM, pulse coincident with START
      clear_stim();
      stim_start[1] = 1'b1;
      stim_start[4] = 1'b1;
      set_pulse(0, 1, 15'h0A0A);
      set_pulse(3, 0, 15'h0B0B);
      set_pulse(5, 3, 15'h0C0C);
      set_pulse(8, 2, 15'h0D0D);
      start_in_stream = 1'b1;
      run_collect(1'b1);
      run_stream(-1);

      // Randomized lines with sparse pulses and random back-pressure
      for (int r = 0; r < 8; r++) begin
         clear_stim();
         for (int j = 0; j < TO; j++) begin
            stim_pulse[j] = NP'($urandom()) & NP'($urandom()) & NP'($urandom());
            if (r == 5) stim_pulse[j][1] = 1'b0;
            stim_start[j] = ($urandom_range(0, 7) == 0);
         end
         rdy_len = 16;
         for (int c = 0; c < 16; c++) rdy_pat[c] = 1'($urandom_range(0, 1));
         start_in_stream = 1'($urandom_range(0, 1));
         run_collect(1'($urandom_range(0, 1)));
         run_stream(-1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/line_period_capture.md
# line_period_capture

Per-line capture and readout stage sitting directly downstream of the per-pixel `frequency_counter` array. After a pixel line has been loaded, it latches each pixel's first valid `PERIOD` measurement, qualified by that pixel's `PULSE`. It then streams the captured periods out one pixel per handshake, in pixel order, over a valid/ready interface. A timeout bounds line time when a pixel never produces a pulse. This replaces bench-side polling of every counter with one synthesizable readout path.

## Interface
- `NUM_PIXELS`, default 8: number of pixels in a line (≥2).
- `COUNTER_BITS`, default 15: width of each period value.
- `TIMEOUT_CYCLES`, default 4096: maximum COLLECT duration in clocks (≥2).
- `IDX_BITS`, default `$clog2(NUM_PIXELS)`: pixel index width.

Ports:
- `CLK`  in  1  system clock; all logic on rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `START`  in  1  one-cycle pulse issued after the shift-register load; arms a capture.
- `PERIOD_IN`  in  NUM_PIXELS*COUNTER_BITS  packed periods; pixel i occupies `[i*COUNTER_BITS +: COUNTER_BITS]`.
- `PULSE_IN`  in  NUM_PIXELS  per-pixel measurement-valid pulses.
- `DATA_OUT`  out  COUNTER_BITS  captured period of pixel `INDEX_OUT`.
- `INDEX_OUT`  out  IDX_BITS  pixel index of the current beat.
- `VALID_OUT`  out  1  beat available.
- `READY_IN`  in  1  consumer accepts the beat.
- `LAST_OUT`  out  1  current beat is pixel NUM_PIXELS-1.
- `BUSY`  out  1  high in any state other than IDLE.
- `TIMEOUT_FLAG`  out  1  the last line ended by timeout. Held until the next START.
- `DONE`  out  1  one-cycle pulse after the final beat is accepted.

## Operation
- FSM states:
  - IDLE: waiting for START.
  - COLLECT: capturing per-pixel periods.
  - STREAM: emitting beats over valid/ready.
- IDLE → COLLECT when START is high. On that edge:
  - clear the captured mask;
  - clear the timeout counter and TIMEOUT_FLAG;
  - preset all capture registers to all-ones (sentinel for "no measurement").
- START is ignored outside IDLE.
- COLLECT, each edge:
  - For every i with `PULSE_IN[i]=1` and `mask[i]=0`: capture the pixel-i slice of `PERIOD_IN` and set `mask[i]`.
  - Later pulses on an already-captured pixel are ignored (first measurement wins).
  - Multiple pixels pulsing on the same edge are all captured.
- COLLECT → STREAM when the mask (including captures made on this edge) is all ones.
- COLLECT → STREAM on timeout: timeout counter equals TIMEOUT_CYCLES-1 and the mask is not complete after this edge's captures.
  - Set TIMEOUT_FLAG.
  - Uncaptured pixels keep the all-ones sentinel.
- If completion and timeout coincide on the same edge, completion wins and TIMEOUT_FLAG stays 0.
- STREAM:
  - beat index starts at 0;
  - `VALID_OUT=1`;
  - `DATA_OUT` = capture register[index];
  - `LAST_OUT = (index == NUM_PIXELS-1)`.
  - When `VALID_OUT & READY_IN`: index increments.
  - On the LAST beat: go to IDLE, pulse DONE for one cycle, reset index to 0.
- While VALID_OUT is high and READY_IN is low, DATA_OUT, INDEX_OUT and LAST_OUT are held stable.
- `PULSE_IN` is ignored in IDLE and STREAM.
- Arithmetic: the timeout counter is `$clog2(TIMEOUT_CYCLES)` bits wide and never wraps; it stops at TIMEOUT_CYCLES-1.

## Timing
- Reset values (async on RST, all outputs):
  - state IDLE;
  - `VALID_OUT=0`, `LAST_OUT=0`, `BUSY=0`, `DONE=0`, `TIMEOUT_FLAG=0`;
  - `INDEX_OUT=0`, `DATA_OUT=0`;
  - mask 0, counter 0.
- RST mid-COLLECT or mid-STREAM aborts immediately. No DONE is produced, and captured data is discarded.
- START sampled at edge k: BUSY is high from edge k. The first edge that can capture is k+1; a pulse coincident with START is not captured.
- Final capture at edge m: VALID_OUT rises after edge m, with index 0 presented in cycle m+1.
- Streaming throughput: one beat per cycle when READY_IN is held high. A full line takes NUM_PIXELS cycles in STREAM.
- DONE is high for the cycle after the edge that accepts the LAST beat; BUSY is low in that same cycle.
- Worst-case COLLECT duration: TIMEOUT_CYCLES edges after entry.
- Outputs are driven from registers or from a mux of registers only; there is no combinational path from inputs to outputs.

## Test plan
All scenarios use NUM_PIXELS=4, COUNTER_BITS=15, TIMEOUT_CYCLES=64.

1. Pulses staggered on pixels 2, 0, 3, 1 with periods 0x0019, 0x00FA, 0x0005, 0x0C35; READY_IN high → beats 0x00FA, 0x0C35, 0x0019, 0x0005 on indices 0–3 in consecutive cycles, LAST_OUT on index 3, DONE one cycle later, TIMEOUT_FLAG=0.
2. All four pixels pulse on the same edge, plus repeat pulses on pixel 1 with a different period → all four captured at once; STREAM entered next cycle; pixel 1 reports its first value.
3. Pixel 3 never pulses → STREAM after 64 COLLECT edges; pixel 3 reads 0x7FFF; TIMEOUT_FLAG=1 until the next START.
4. READY_IN toggles 1,0,0,1,1,0,1 during STREAM → exactly 4 beats, data and index stable while stalled, no beat duplicated or skipped.
5. RST asserted asynchronously mid-STREAM at index 2, then a new START → outputs return to reset values immediately with no DONE; the new line streams from index 0 with fresh captures.
6. START pulsed again during COLLECT and during STREAM, and a pulse coincident with START → the extra STARTs are ignored, and the coincident pulse does not set the mask.
